// File: rtl/tick_timer.sv
// -----------------------------------------------------------------------------
// tick_timer
//
// Programmable tick timer. A prescaler divides clk_i by DIV = CLK_HZ/TICK_HZ
// and each prescaler wrap moves a CNT_W-bit counter one step. The counter runs
// up (0 -> limit) or down (limit -> 0). In one-shot mode it stops in DONE at
// the terminal value. In wrap mode it reloads its initial value on the tick
// after the terminal.
//
// Ports
//   clk_i      system clock, rising edge
//   rst_ni     asynchronous active-low reset
//   start_i    pulse: latch dir/wrap/limit, load the initial count, run
//   clear_i    synchronous return to IDLE with count = 0
//   pause_i    level: freeze prescaler and count while RUN/PAUSE
//   dir_i      0 = count up, 1 = count down (sampled at start)
//   wrap_en_i  1 = periodic reload, 0 = one-shot (sampled at start)
//   limit_i    terminal/initial value (sampled at start)
//   count_o    current count
//   tick_o     one-cycle pulse coincident with each count update
//   expire_o   one-cycle pulse when the count reaches its terminal
//   done_o     high while in DONE
//   running_o  high while in RUN
//
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module tick_timer #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1,
    parameter int CNT_W   = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             pause_i,
    input  logic             dir_i,
    input  logic             wrap_en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tick_o,
    output logic             expire_o,
    output logic             done_o,
    output logic             running_o
);

    // Guard the division so that a bad TICK_HZ reaches the elaboration
    // check below instead of failing inside a constant expression.
    localparam int DIV     = (TICK_HZ > 0) ? (CLK_HZ / TICK_HZ) : 0;
    localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'((DIV > 0) ? (DIV - 1) : 0);

    // The divider must be an exact integer of at least 1.
    generate
        if (TICK_HZ <= 0) begin : g_bad_tick_hz
            $error("tick_timer: TICK_HZ must be positive");
        end else if ((DIV < 1) || ((CLK_HZ % TICK_HZ) != 0)) begin : g_bad_div
            $error("tick_timer: CLK_HZ/TICK_HZ must be an integer >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q,   state_d;
    logic [PRESC_W-1:0] presc_q,   presc_d;
    logic [CNT_W-1:0]   count_q,   count_d;
    logic               tick_q,    tick_d;
    logic               expire_q,  expire_d;
    logic               done_q,    done_d;
    logic               running_q, running_d;

    // Configuration latched at start
    logic               dir_q,   dir_d;
    logic               wrap_q,  wrap_d;
    logic [CNT_W-1:0]   limit_q, limit_d;

    // Derived from the latched configuration
    logic [CNT_W-1:0]   step_val;
    logic [CNT_W-1:0]   terminal_val;
    logic [CNT_W-1:0]   initial_val;

    assign step_val     = dir_q ? (count_q - 1'b1) : (count_q + 1'b1);
    assign terminal_val = dir_q ? '0 : limit_q;
    assign initial_val  = dir_q ? limit_q : '0;

    // -------------------------------------------------------------------------
    // Next-state logic. Priority is clear > start > pause > counting.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        count_d  = count_q;
        tick_d   = 1'b0;
        expire_d = 1'b0;
        dir_d    = dir_q;
        wrap_d   = wrap_q;
        limit_d  = limit_q;

        if (clear_i) begin
            state_d = S_IDLE;
            presc_d = '0;
            count_d = '0;
        end else if (start_i) begin
            dir_d   = dir_i;
            wrap_d  = wrap_en_i;
            limit_d = limit_i;
            presc_d = '0;
            count_d = dir_i ? limit_i : '0;
            if (limit_i == '0) begin
                // The count is already at its terminal, so there is nothing
                // to count.
                state_d  = S_DONE;
                expire_d = 1'b1;
            end else begin
                state_d = S_RUN;
            end
        end else if ((state_q == S_RUN) || (state_q == S_PAUSE)) begin
            if (pause_i) begin
                state_d = S_PAUSE;
            end else begin
                // Leaving PAUSE counts this cycle too. A pause therefore
                // delays the next tick by exactly the number of paused cycles.
                state_d = S_RUN;
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    if (count_q == terminal_val) begin
                        // Sitting at the terminal while still running only
                        // happens in wrap mode, so reload the initial value.
                        count_d = initial_val;
                    end else begin
                        count_d = step_val;
                        if (step_val == terminal_val) begin
                            expire_d = 1'b1;
                            if (!wrap_q) begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
        end

        // done/running are stored in their own flops, decoded from the next state
        done_d    = (state_d == S_DONE);
        running_d = (state_d == S_RUN);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            count_q   <= '0;
            tick_q    <= 1'b0;
            expire_q  <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            dir_q     <= 1'b0;
            wrap_q    <= 1'b0;
            limit_q   <= '0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            tick_q    <= tick_d;
            expire_q  <= expire_d;
            done_q    <= done_d;
            running_q <= running_d;
            dir_q     <= dir_d;
            wrap_q    <= wrap_d;
            limit_q   <= limit_d;
        end
    end

    assign count_o   = count_q;
    assign tick_o    = tick_q;
    assign expire_o  = expire_q;
    assign done_o    = done_q;
    assign running_o = running_q;

endmodule

// File: tb/tb_tick_timer.sv
// -----------------------------------------------------------------------------
// tb_tick_timer
//
// Directed testbench for tick_timer with DIV = 10 and CNT_W = 4. Inputs are
// driven and outputs are sampled on the falling edge, half a cycle away from
// the active edge. Each comparison checks the packed vector
// {count, tick, expire, done, running}.
// -----------------------------------------------------------------------------
module tb_tick_timer;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start   = 1'b0;
    logic       clear   = 1'b0;
    logic       pause   = 1'b0;
    logic       dir     = 1'b0;
    logic       wrap_en = 1'b0;
    logic [3:0] limit   = 4'd0;
    logic [3:0] count;
    logic       tick;
    logic       expire;
    logic       done;
    logic       running;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_v;
    wire  [7:0] obs_w = {count, tick, expire, done, running};

    tick_timer #(
        .CLK_HZ  (10),
        .TICK_HZ (1),
        .CNT_W   (4)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start),
        .clear_i   (clear),
        .pause_i   (pause),
        .dir_i     (dir),
        .wrap_en_i (wrap_en),
        .limit_i   (limit),
        .count_o   (count),
        .tick_o    (tick),
        .expire_o  (expire),
        .done_o    (done),
        .running_o (running)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench just after the edge that sampled start (E0).
    task automatic pulse_start(input logic d, input logic w, input logic [3:0] l);
        dir     = d;
        wrap_en = w;
        limit   = l;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        exp_v = {4'd0, 4'b0000};
        checks++;
        if (obs_w !== exp_v) begin
            failures++;
            $display("FAIL reset_held: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                     obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
        end
        rst_n = 1'b1;
        step(3);
        checks++;
        if (obs_w !== exp_v) begin
            failures++;
            $display("FAIL reset_idle: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                     obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
        end
        $display("test_reset done: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_up_oneshot();
        pulse_start(1'b0, 1'b0, 4'd3);
        exp_v = {4'd0, 4'b0001};
        checks++;
        if (obs_w !== exp_v) begin
            failures++;
            $display("FAIL up_start: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                     obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
        end
        for (int k = 1; k <= 3; k++) begin
            step(9);
            exp_v = {4'(k - 1), 4'b0001};
            checks++;
            if (obs_w !== exp_v) begin
                failures++;
                $display("FAIL up_pre_tick%0d: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                         k, obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
            end
            step(1);
            exp_v = {4'(k), 1'b1, (k == 3), (k == 3), (k != 3)};
            checks++;
            if (obs_w !== exp_v) begin
                failures++;
                $display("FAIL up_tick%0d: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                         k, obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
            end
        end
        step(1);
        exp_v = {4'd3, 4'b0010};
        checks++;
        if (obs_w !== exp_v) begin
            failures++;
            $display("FAIL up_done_after: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                     obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
        end
        step(50);
        checks++;
        if (obs_w !== exp_v) begin
            failures++;
            $display("FAIL up_done_hold: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                     obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
        end
        $display("test_up_oneshot done: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_down_wrap();
        logic [3:0] exp_cnt [4];
        logic       exp_exp [4];
        logic [3:0] prev;
        exp_cnt = '{4'd1, 4'd0, 4'd2, 4'd1};
        exp_exp = '{1'b0, 1'b1, 1'b0, 1'b0};
        pulse_start(1'b1, 1'b1, 4'd2);
        exp_v = {4'd2, 4'b0001};
        checks++;
        if (obs_w !== exp_v) begin
            failures++;
            $display("FAIL down_start: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                     obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
        end
        prev = 4'd2;
        for (int k = 0; k < 4; k++) begin
            step(9);
            exp_v = {prev, 4'b0001};
            checks++;
            if (obs_w !== exp_v) begin
                failures++;
                $display("FAIL down_pre_tick%0d: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                         k, obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
            end
            step(1);
            exp_v = {exp_cnt[k], 1'b1, exp_exp[k], 1'b0, 1'b1};
            checks++;
            if (obs_w !== exp_v) begin
                failures++;
                $display("FAIL down_tick%0d: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                         k, obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
            end
            prev = exp_cnt[k];
        end
        $display("test_down_wrap done: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_pause();
        pulse_start(1'b0, 1'b0, 4'd5);
        step(10);
        exp_v = {4'd1, 4'b1001};
        checks++;
        if (obs_w !== exp_v) begin
            failures++;
            $display("FAIL pause_tick1: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                     obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
        end
        step(3);
        pause = 1'b1;                 // sampled at E0+14 .. E0+20
        step(1);
        exp_v = {4'd1, 4'b0000};
        checks++;
        if (obs_w !== exp_v) begin
            failures++;
            $display("FAIL pause_enter: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                     obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
        end
        step(6);
        checks++;
        if (obs_w !== exp_v) begin
            failures++;
            $display("FAIL pause_frozen: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                     obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
        end
        pause = 1'b0;
        step(6);                      // post E0+26: one cycle short of the tick
        exp_v = {4'd1, 4'b0001};
        checks++;
        if (obs_w !== exp_v) begin
            failures++;
            $display("FAIL pause_resume_early: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                     obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
        end
        step(1);                      // E0+27
        exp_v = {4'd2, 4'b1001};
        checks++;
        if (obs_w !== exp_v) begin
            failures++;
            $display("FAIL pause_tick2_at27: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                     obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
        end
        $display("test_pause done: checks=%0d failures=%0d", checks, failures);
    endtask

    // Follows test_pause: the timer is in RUN with count = 2.
    task automatic test_priority();
        clear = 1'b1;
        start = 1'b1;
        dir   = 1'b1;
        limit = 4'd9;
        step(1);
        clear = 1'b0;
        start = 1'b0;
        exp_v = {4'd0, 4'b0000};
        checks++;
        if (obs_w !== exp_v) begin
            failures++;
            $display("FAIL prio_clear_wins: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                     obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
        end
        step(12);
        checks++;
        if (obs_w !== exp_v) begin
            failures++;
            $display("FAIL prio_idle_hold: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                     obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
        end
        pulse_start(1'b0, 1'b0, 4'd0);
        exp_v = {4'd0, 4'b0110};
        checks++;
        if (obs_w !== exp_v) begin
            failures++;
            $display("FAIL prio_limit0_expire: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                     obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
        end
        step(1);
        exp_v = {4'd0, 4'b0010};
        checks++;
        if (obs_w !== exp_v) begin
            failures++;
            $display("FAIL prio_limit0_done: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                     obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
        end
        $display("test_priority done: checks=%0d failures=%0d", checks, failures);
    endtask

    // Follows test_priority: the timer is in DONE.
    task automatic test_restart_reset();
        pulse_start(1'b1, 1'b0, 4'd7);
        exp_v = {4'd7, 4'b0001};
        checks++;
        if (obs_w !== exp_v) begin
            failures++;
            $display("FAIL restart_from_done: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                     obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
        end
        step(5);
        checks++;
        if (obs_w !== exp_v) begin
            failures++;
            $display("FAIL restart_mid_period: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                     obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
        end
        #2 rst_n = 1'b0;              // the next rising edge is still 3 time units away
        #1;
        exp_v = {4'd0, 4'b0000};
        checks++;
        if (obs_w !== exp_v) begin
            failures++;
            $display("FAIL async_reset: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                     obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(2);
        $display("test_restart_reset done: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_start_paused();
        pause = 1'b1;
        pulse_start(1'b0, 1'b1, 4'd3);
        exp_v = {4'd0, 4'b0001};
        checks++;
        if (obs_w !== exp_v) begin
            failures++;
            $display("FAIL start_paused_run: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                     obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
        end
        step(1);
        exp_v = {4'd0, 4'b0000};
        checks++;
        if (obs_w !== exp_v) begin
            failures++;
            $display("FAIL start_paused_pause: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                     obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
        end
        step(20);
        checks++;
        if (obs_w !== exp_v) begin
            failures++;
            $display("FAIL start_paused_hold: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                     obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
        end
        pause = 1'b0;
        step(9);
        exp_v = {4'd0, 4'b0001};
        checks++;
        if (obs_w !== exp_v) begin
            failures++;
            $display("FAIL start_paused_pre: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                     obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
        end
        step(1);
        exp_v = {4'd1, 4'b1001};
        checks++;
        if (obs_w !== exp_v) begin
            failures++;
            $display("FAIL start_paused_tick: got cnt=%0d t/e/d/r=%b want cnt=%0d t/e/d/r=%b",
                     obs_w[7:4], obs_w[3:0], exp_v[7:4], exp_v[3:0]);
        end
        $display("test_start_paused done: checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        test_reset();
        test_up_oneshot();
        test_down_wrap();
        test_pause();
        test_priority();
        test_restart_reset();
        test_start_paused();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tick_timer.md
Name: tick_timer

Overview:
- Parametrised successor to the team's fixed one-second timer.
- Divides the system clock into a programmable tick rate and drives a CNT_W-bit counter that counts up or down between 0 and a runtime limit.
- Supports pause, clear, wrap (periodic) or one-shot mode, and flags expiry.
- Feeds game/turn timers and 7-segment display logic in the lab top level.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- TICK_HZ, 1, tick rate in Hz. DIV = CLK_HZ/TICK_HZ, integer, >= 1 (elaboration error otherwise).
- CNT_W, 4, counter width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  pulse: load initial value and run; restarts from any state.
- clear  in  1  synchronous: go to IDLE, count=0.
- pause  in  1  level: freeze prescaler and count while high.
- dir  in  1  0 = count up 0→limit; 1 = count down limit→0. Sampled at start only.
- wrap_en  in  1  1 = periodic reload at terminal; 0 = one-shot. Sampled at start only.
- limit  in  CNT_W  terminal/initial value. Sampled at start only.
- count  out  CNT_W  current count.
- tick  out  1  one-cycle pulse coincident with every count update.
- expire  out  1  one-cycle pulse when count reaches its terminal.
- done  out  1  level, high in DONE state.
- running  out  1  level, high in RUN state.

Behaviour:
- Reset (rst=0, async): state=IDLE, prescaler=0, count=0, tick=0, expire=0, done=0, running=0. Latched dir/wrap_en/limit are cleared to 0.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Priority each cycle: clear > start > pause > normal counting.
- clear (any state): next state IDLE, count=0, prescaler=0, tick/expire=0.
- start (any state): latch dir, wrap_en and limit; prescaler=0.
  - count = limit if dir=1, else 0.
  - If limit=0: go to DONE and pulse expire on the next edge.
  - Otherwise go to RUN.
- RUN, pause=1: go to PAUSE with prescaler and count held.
- PAUSE, pause=0: return to RUN; the prescaler resumes from its held value with no extra cycle.
- RUN, pause=0: prescaler increments each cycle. When prescaler == DIV-1:
  - prescaler=0, tick=1.
  - count steps ±1 per the latched dir.
  - If the new count equals the terminal (limit when up, 0 when down), expire=1 in the same cycle.
  - On the next tick after terminal:
    - wrap_en=1: count reloads the initial value (0 up, limit down), state stays RUN, tick=1, no expire.
    - wrap_en=0: state goes to DONE at the terminal edge itself; count holds the terminal.
- DONE: count held, done=1. Leaves only via start, clear or reset.
- Latency: start sampled at edge E0; first tick/count change occurs at edge E0+DIV. Period between ticks is exactly DIV cycles while unpaused.
- DIV=1: tick asserts every RUN cycle.
- Count arithmetic is CNT_W bits. No overflow is possible because limit bounds the range.
- pause in IDLE or DONE: ignored.
- start while pause=1: goes to RUN this edge, then PAUSE on the following edge if pause is still high.
- Reset mid-count: immediate async return to reset values.

Test Plan:
- (Bench uses CLK_HZ=10, TICK_HZ=1 → DIV=10, CNT_W=4.)
- Reset/up one-shot: rst low then high; start with dir=0, wrap_en=0, limit=3 → count 1,2,3 at edges +10,+20,+30. expire and tick pulse at +30; done=1, running=0. count stays 3 for 50 further cycles.
- Down wrap: start with dir=1, wrap_en=1, limit=2 → count 2→1→0 (expire at 0)→2→1. tick every 10 cycles, done never set.
- Pause: up, limit=5; assert pause 4 cycles after the first tick, hold 7 cycles → the second tick arrives at cycle 27 instead of 20; count and prescaler frozen during pause.
- Priority: assert clear and start together while RUN at count=2 → IDLE, count=0. Then start alone with limit=0 → DONE and expire one edge later, count=0.
- Restart/reset mid-op: start again in DONE with new limit=7, dir=1 → count=7, running=1. Drop rst mid-period → all outputs 0 asynchronously, before the next clk edge.
